// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: state encoding, register
// constants and the bundle of per-stage control outputs with canned settings.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DMISS = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  localparam logic [3:0] REG_R0 = 4'h0;

  typedef struct packed {
    logic pc_write_en;
    logic ifid_stall;
    logic ifid_nop;
    logic idex_stall;
    logic idex_nop;
    logic exmem_stall;
    logic exmem_nop;
    logic memwb_nop;
    logic halted;
  } ctrl_t;

  // Free-running pipeline: fetch advances, nothing held, nothing squashed.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c             = '0;
    c.pc_write_en = 1'b1;
    return c;
  endfunction

  // D-cache freeze: hold everything up to EX/MEM, bubble into MEM/WB.
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c             = '0;
    c.ifid_stall  = 1'b1;
    c.idex_stall  = 1'b1;
    c.exmem_stall = 1'b1;
    c.memwb_nop   = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_halt();
    ctrl_t c;
    c           = '0;
    c.ifid_nop  = 1'b1;
    c.idex_nop  = 1'b1;
    c.exmem_nop = 1'b1;
    c.memwb_nop = 1'b1;
    c.halted    = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c           = ctrl_halt();
    c.halted    = 1'b0;
    return c;
  endfunction

  function automatic ctrl_t ctrl_load_use();
    ctrl_t c;
    c            = '0;
    c.ifid_stall = 1'b1;
    c.idex_nop   = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_branch();
    ctrl_t c;
    c             = '0;
    c.pc_write_en = 1'b1;
    c.ifid_nop    = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_imiss();
    ctrl_t c;
    c          = '0;
    c.ifid_nop = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs and stage-control outputs between the pipeline and its sequencer.
// master = pipeline/cache side, slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             IDEX_MemRead;
  logic [3:0]       IDEX_DstReg;
  logic [3:0]       IFID_SrcReg1;
  logic [3:0]       IFID_SrcReg2;
  logic             IFID_UsesSrc2;
  logic             branch_taken;
  logic             icache_miss;
  logic             dcache_miss;
  logic             mem_access;
  logic             halt_in;

  logic             PC_write_en;
  logic             IFID_stall;
  logic             IFID_nop;
  logic             IDEX_stall;
  logic             IDEX_nop;
  logic             EXMEM_stall;
  logic             EXMEM_nop;
  logic             MEMWB_nop;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output IDEX_MemRead, IDEX_DstReg, IFID_SrcReg1, IFID_SrcReg2, IFID_UsesSrc2,
    output branch_taken, icache_miss, dcache_miss, mem_access, halt_in,
    input  PC_write_en, IFID_stall, IFID_nop, IDEX_stall, IDEX_nop,
    input  EXMEM_stall, EXMEM_nop, MEMWB_nop, halted, stall_cycles
  );

  modport slave (
    input  IDEX_MemRead, IDEX_DstReg, IFID_SrcReg1, IFID_SrcReg2, IFID_UsesSrc2,
    input  branch_taken, icache_miss, dcache_miss, mem_access, halt_in,
    output PC_write_en, IFID_stall, IFID_nop, IDEX_stall, IDEX_nop,
    output EXMEM_stall, EXMEM_nop, MEMWB_nop, halted, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use comparator: flags an ID instruction that reads the register a load
// in EX is about to write. R0 is hardwired, so it never creates a hazard.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       idex_mem_read,
  input  logic [3:0] idex_dst_reg,
  input  logic [3:0] ifid_src_reg1,
  input  logic [3:0] ifid_src_reg2,
  input  logic       ifid_uses_src2,
  output logic       lu
);
  logic match1;
  logic match2;

  assign match1 = (idex_dst_reg == ifid_src_reg1);
  assign match2 = ifid_uses_src2 & (idex_dst_reg == ifid_src_reg2);
  assign lu     = idex_mem_read & (idex_dst_reg != REG_R0) & (match1 | match2);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Define STALL_CNT_EN to build
// the saturating stall-cycle counter; otherwise stall_cycles reads 0.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   lu;
  logic   freeze;

  load_use_detect u_lu (
    .idex_mem_read  (hz.IDEX_MemRead),
    .idex_dst_reg   (hz.IDEX_DstReg),
    .ifid_src_reg1  (hz.IFID_SrcReg1),
    .ifid_src_reg2  (hz.IFID_SrcReg2),
    .ifid_uses_src2 (hz.IFID_UsesSrc2),
    .lu             (lu)
  );

  // Once frozen, the freeze lasts for as long as the fill does, regardless of
  // whether the access is still flagged.
  always_comb begin
    freeze = 1'b0;
    if (state_q == ST_DMISS) begin
      freeze = hz.dcache_miss;
    end else if (state_q == ST_RUN) begin
      freeze = hz.dcache_miss & hz.mem_access;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl    = ctrl_idle();
    if (state_q == ST_HALT) begin
      ctrl = ctrl_halt();
    end else if (freeze) begin
      ctrl    = ctrl_freeze();
      state_d = ST_DMISS;
    end else if (hz.halt_in) begin
      ctrl    = ctrl_halt();
      state_d = ST_HALT;
    end else begin
      // Branch beats I-miss so a redirect is never dropped behind a fill.
      state_d = ST_RUN;
      if (lu) begin
        ctrl = ctrl_load_use();
      end else if (hz.branch_taken) begin
        ctrl = ctrl_branch();
      end else if (hz.icache_miss) begin
        ctrl = ctrl_imiss();
      end
    end
    if (rst) begin
      ctrl = ctrl_reset();
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign hz.PC_write_en = ctrl.pc_write_en;
  assign hz.IFID_stall  = ctrl.ifid_stall;
  assign hz.IFID_nop    = ctrl.ifid_nop;
  assign hz.IDEX_stall  = ctrl.idex_stall;
  assign hz.IDEX_nop    = ctrl.idex_nop;
  assign hz.EXMEM_stall = ctrl.exmem_stall;
  assign hz.EXMEM_nop   = ctrl.exmem_nop;
  assign hz.MEMWB_nop   = ctrl.memwb_nop;
  assign hz.halted      = ctrl.halted;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Halted cycles are not stalls; the counter pins at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != ST_HALT) && !ctrl.pc_write_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall_cycles = stall_cnt_q;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Expected-output vectors, ordered {PC_we, IFID_stall, IFID_nop, IDEX_stall,
  // IDEX_nop, EXMEM_stall, EXMEM_nop, MEMWB_nop, halted}.
  localparam logic [8:0] V_IDLE   = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] V_RESET  = 9'b0_0_1_0_1_0_1_1_0;
  localparam logic [8:0] V_HALT   = 9'b0_0_1_0_1_0_1_1_1;
  localparam logic [8:0] V_FREEZE = 9'b0_1_0_1_0_1_0_1_0;
  localparam logic [8:0] V_LU     = 9'b0_1_0_0_1_0_0_0_0;
  localparam logic [8:0] V_BRANCH = 9'b1_0_1_0_0_0_0_0_0;
  localparam logic [8:0] V_IMISS  = 9'b0_0_1_0_0_0_0_0_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model: is the core halted, is a data fill in progress, stall count so far.
  bit   m_halted = 1'b0;
  bit   m_filling = 1'b0;
  int   m_stalls = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [8:0] model_ctrl();
    bit lu;
    lu = hz.IDEX_MemRead && (hz.IDEX_DstReg != 0) &&
         ((hz.IDEX_DstReg == hz.IFID_SrcReg1) ||
          (hz.IFID_UsesSrc2 && (hz.IDEX_DstReg == hz.IFID_SrcReg2)));
    if (rst)                                                         return V_RESET;
    if (m_halted)                                                    return V_HALT;
    if (hz.dcache_miss && (m_filling || hz.mem_access))              return V_FREEZE;
    if (hz.halt_in)                                                  return V_HALT;
    if (lu)                                                          return V_LU;
    if (hz.branch_taken)                                             return V_BRANCH;
    if (hz.icache_miss)                                              return V_IMISS;
    return V_IDLE;
  endfunction

  function automatic int model_count();
`ifdef STALL_CNT_EN
    return m_stalls;
`else
    return 0;
`endif
  endfunction

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic step();
    logic [8:0] exp_v;
    logic [8:0] got_v;
    @(negedge clk);
    exp_v = model_ctrl();
    got_v = {hz.PC_write_en, hz.IFID_stall, hz.IFID_nop, hz.IDEX_stall, hz.IDEX_nop,
             hz.EXMEM_stall, hz.EXMEM_nop, hz.MEMWB_nop, hz.halted};
    $display("cyc %0d rst=%0b ctrl=%b exp=%b cnt=%0d", cyc, rst, got_v, exp_v, hz.stall_cycles);
    check_eq("ctrl", 32'(got_v), 32'(exp_v));
    check_eq("stall_cycles", 32'(hz.stall_cycles), 32'(model_count()));
    @(posedge clk);
    if (rst) begin
      m_halted  = 1'b0;
      m_filling = 1'b0;
      m_stalls  = 0;
    end else begin
      if (!m_halted && !exp_v[8]) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
      if (!m_halted) begin
        m_filling = (exp_v == V_FREEZE);
        m_halted  = (exp_v == V_HALT);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input bit r, input bit ld, input bit [3:0] dst, input bit [3:0] s1,
                       input bit [3:0] s2, input bit u2, input bit br, input bit ic,
                       input bit dm, input bit ma, input bit hl);
    rst              = r;
    hz.IDEX_MemRead  = ld;
    hz.IDEX_DstReg   = dst;
    hz.IFID_SrcReg1  = s1;
    hz.IFID_SrcReg2  = s2;
    hz.IFID_UsesSrc2 = u2;
    hz.branch_taken  = br;
    hz.icache_miss   = ic;
    hz.dcache_miss   = dm;
    hz.mem_access    = ma;
    hz.halt_in       = hl;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 3, 3, 0, 0, 1, 1, 1, 1, 1);
    idle(1);
    // Load-use on R3, then its R0 variant.
    drive(0, 1, 3, 3, 1, 1, 0, 0, 0, 0, 0);
    idle(1);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 5, 1, 5, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 5, 1, 5, 1, 0, 0, 0, 0, 0);
    // Four-cycle data miss, with a load-use hazard subsumed by the freeze.
    for (int i = 0; i < 4; i++) drive(0, 1, 3, 3, 1, 1, 0, 0, 1, 1, 0);
    drive(0, 1, 3, 3, 1, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(1);
    // Branch overrides I-miss.
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Halt and hold for 20 cycles under arbitrary hazards, then reset.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++)
      drive(0, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Halt ignored during a fill; reset in the middle of a fill.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Long miss to drive the counter into saturation.
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);
    // Random traffic: narrow register range to provoke matches, rare halt/reset.
    for (int i = 0; i < 400; i++) begin
      bit dm_b;
      dm_b = ($urandom_range(0, 3) == 0) || (hz.dcache_miss && ($urandom_range(0, 3) != 0));
      drive(($urandom_range(0, 39) == 0), 1'($urandom), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 1'($urandom), dm_b, 1'($urandom), ($urandom_range(0, 59) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
